// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the pipeline control path.
//   pipe_state_t : sequencing state of the hazard/halt controller
//   latch_ctl_t  : enable/flush pair driven to one pipeline latch
// Constants name the three latch behaviours the controller uses.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } latch_ctl_t;

  // Latch holds its contents.
  localparam latch_ctl_t LATCH_HOLD   = '{en: 1'b0, flush: 1'b0};
  // Latch captures the upstream stage.
  localparam latch_ctl_t LATCH_PASS   = '{en: 1'b1, flush: 1'b0};
  // Latch captures a bubble (flush only acts together with enable).
  localparam latch_ctl_t LATCH_BUBBLE = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   CLK   : clock, rising edge
//   nRST  : synchronous active-low reset, clears the count
//   inc   : add one this cycle (ignored once saturated)
//   count : current count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_controller.sv
// -----------------------------------------------------------------------------
// pipeline_controller
// Hazard and sequencing unit for the five-stage pipeline. Produces the
// enable/flush pair for each pipeline latch and the PC write enable in the
// same cycle as its inputs, drains the pipe on a halt, and keeps saturating
// stall / redirect performance counters.
//   CLK, nRST                 : clock (rising edge), synchronous active-low reset
//   ihit, dhit                : fetch / data access completes this cycle
//   dmem_req                  : MEM-stage instruction issues a data access
//   mispredict                : EX-stage redirect required
//   load_use                  : ID-stage instruction depends on a load in EX
//   halt_mem                  : halt instruction is in MEM
//   pc_en                     : PC loads next PC or redirect target
//   <latch>_en, <latch>_flush : IF/ID, ID/EX, EX/MEM, MEM/WB latch controls
//   halted                    : core stopped, sticky until reset
//   stall_cycles              : RUN cycles with pc_en low
//   flush_count               : accepted mispredict redirects
// -----------------------------------------------------------------------------
module pipeline_controller
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             mispredict,
  input  logic             load_use,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  pipe_state_t r_state;

  logic       w_mem_busy;
  logic       w_pc_en;
  logic       w_flush_inc;
  logic       w_stall_inc;
  latch_ctl_t w_if_id;
  latch_ctl_t w_id_ex;
  latch_ctl_t w_ex_mem;
  latch_ctl_t w_mem_wb;

  // A data access completing this cycle lets MEM advance now.
  assign w_mem_busy = dmem_req & ~dhit;

  // Priority decode. Outside RUN, and while in reset, everything holds.
  always_comb begin
    w_pc_en     = 1'b0;
    w_flush_inc = 1'b0;
    w_if_id     = LATCH_HOLD;
    w_id_ex     = LATCH_HOLD;
    w_ex_mem    = LATCH_HOLD;
    w_mem_wb    = LATCH_HOLD;
    if (nRST && (r_state == RUN)) begin
      if (w_mem_busy) begin
        // Whole pipe frozen; a pending mispredict stays visible in EX.
        w_pc_en = 1'b0;
      end else if (halt_mem) begin
        // Halt is older than anything behind it, so it beats a redirect.
        w_if_id  = LATCH_BUBBLE;
        w_id_ex  = LATCH_BUBBLE;
        w_ex_mem = LATCH_BUBBLE;
        w_mem_wb = LATCH_PASS;
      end else if (mispredict) begin
        // Redirect target comes from EX, so no fetch is needed to load it.
        w_pc_en     = 1'b1;
        w_flush_inc = 1'b1;
        w_if_id     = LATCH_BUBBLE;
        w_id_ex     = LATCH_BUBBLE;
        w_ex_mem    = LATCH_PASS;
        w_mem_wb    = LATCH_PASS;
      end else if (load_use) begin
        // Hold IF/ID and PC, inject one bubble into EX.
        w_if_id  = LATCH_HOLD;
        w_id_ex  = LATCH_BUBBLE;
        w_ex_mem = LATCH_PASS;
        w_mem_wb = LATCH_PASS;
      end else if (!ihit) begin
        w_if_id  = LATCH_BUBBLE;
        w_id_ex  = LATCH_PASS;
        w_ex_mem = LATCH_PASS;
        w_mem_wb = LATCH_PASS;
      end else begin
        w_pc_en  = 1'b1;
        w_if_id  = LATCH_PASS;
        w_id_ex  = LATCH_PASS;
        w_ex_mem = LATCH_PASS;
        w_mem_wb = LATCH_PASS;
      end
    end
  end

  // Sequencing: RUN -> DRAIN (one cycle, halt writes back) -> HALTED.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     if (!w_mem_busy && halt_mem) r_state <= DRAIN;
        DRAIN:   r_state <= HALTED;
        HALTED:  r_state <= HALTED;
        default: r_state <= RUN;
      endcase
    end
  end

  assign w_stall_inc = nRST && (r_state == RUN) && !w_pc_en;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_flush_inc),
    .count (flush_count)
  );

  assign pc_en        = w_pc_en;
  assign if_id_en     = w_if_id.en;
  assign if_id_flush  = w_if_id.flush;
  assign id_ex_en     = w_id_ex.en;
  assign id_ex_flush  = w_id_ex.flush;
  assign ex_mem_en    = w_ex_mem.en;
  assign ex_mem_flush = w_ex_mem.flush;
  assign mem_wb_en    = w_mem_wb.en;
  assign mem_wb_flush = w_mem_wb.flush;
  assign halted       = (r_state == HALTED);

endmodule

// File: tb/tb_pipeline_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_controller
// Drives a full-width controller and a narrow-counter controller from the
// same stimulus and compares both against a behavioural model.
// -----------------------------------------------------------------------------
module tb_pipeline_controller;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic nRST, ihit, dhit, dmem_req, mispredict, load_use, halt_mem;

  logic        a_pc, a_ife, a_iff, a_ide, a_idf, a_exe, a_exf, a_mwe, a_mwf, a_halted;
  logic [31:0] a_stall, a_flush;
  logic        b_pc, b_ife, b_iff, b_ide, b_idf, b_exe, b_exf, b_mwe, b_mwf, b_halted;
  logic [3:0]  b_stall, b_flush;

  pipeline_controller #(.CNT_W(32)) dut_a (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .mispredict(mispredict), .load_use(load_use), .halt_mem(halt_mem),
    .pc_en(a_pc), .if_id_en(a_ife), .if_id_flush(a_iff),
    .id_ex_en(a_ide), .id_ex_flush(a_idf), .ex_mem_en(a_exe), .ex_mem_flush(a_exf),
    .mem_wb_en(a_mwe), .mem_wb_flush(a_mwf), .halted(a_halted),
    .stall_cycles(a_stall), .flush_count(a_flush)
  );

  pipeline_controller #(.CNT_W(4)) dut_b (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .mispredict(mispredict), .load_use(load_use), .halt_mem(halt_mem),
    .pc_en(b_pc), .if_id_en(b_ife), .if_id_flush(b_iff),
    .id_ex_en(b_ide), .id_ex_flush(b_idf), .ex_mem_en(b_exe), .ex_mem_flush(b_exf),
    .mem_wb_en(b_mwe), .mem_wb_flush(b_mwf), .halted(b_halted),
    .stall_cycles(b_stall), .flush_count(b_flush)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_no   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_no, got, exp);
  endtask

  // Model: -1 running, 0 draining, 1 stopped; counters kept unbounded.
  int     m_halt_age = -1;
  longint m_stall    = 0;
  longint m_flush    = 0;

  // Control vector order: pc, if_id en/fl, id_ex en/fl, ex_mem en/fl, mem_wb en/fl.
  localparam logic [8:0] V_OFF    = 9'b0_00_00_00_00;
  localparam logic [8:0] V_HALT   = 9'b0_11_11_11_10;
  localparam logic [8:0] V_MISP   = 9'b1_11_11_10_10;
  localparam logic [8:0] V_LU     = 9'b0_00_11_10_10;
  localparam logic [8:0] V_NOHIT  = 9'b0_11_10_10_10;
  localparam logic [8:0] V_NORMAL = 9'b1_10_10_10_10;

  // Which hazard rule wins: 0 off/frozen, 1 halt, 2 redirect, 3 load-use, 4 no fetch, 5 normal.
  function automatic int rule_of();
    if (!nRST || m_halt_age != -1) return 0;
    if (dmem_req && !dhit) return 0;
    if (halt_mem)          return 1;
    if (mispredict)        return 2;
    if (load_use)          return 3;
    if (!ihit)             return 4;
    return 5;
  endfunction

  function automatic logic [8:0] vec_of(input int r);
    case (r)
      1: return V_HALT;
      2: return V_MISP;
      3: return V_LU;
      4: return V_NOHIT;
      5: return V_NORMAL;
      default: return V_OFF;
    endcase
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic cyc(input logic rst, input logic ih, input logic dh, input logic dr,
                     input logic mp, input logic lu, input logic hm);
    int r;
    logic [8:0] ev;
    @(negedge CLK);
    nRST = rst; ihit = ih; dhit = dh; dmem_req = dr;
    mispredict = mp; load_use = lu; halt_mem = hm;
    #1;
    r  = rule_of();
    ev = vec_of(r);
    check("ctrl_a", {a_pc, a_ife, a_iff, a_ide, a_idf, a_exe, a_exf, a_mwe, a_mwf}, ev);
    check("ctrl_b", {b_pc, b_ife, b_iff, b_ide, b_idf, b_exe, b_exf, b_mwe, b_mwf}, ev);
    check("stall_a", a_stall, sat(m_stall, 64'hFFFF_FFFF));
    check("flush_a", a_flush, sat(m_flush, 64'hFFFF_FFFF));
    check("stall_b", b_stall, sat(m_stall, 15));
    check("flush_b", b_flush, sat(m_flush, 15));
    check("halted_a", a_halted, m_halt_age == 1);
    check("halted_b", b_halted, m_halt_age == 1);
    @(posedge CLK);
    cyc_no++;
    if (!rst) begin
      m_halt_age = -1; m_stall = 0; m_flush = 0;
    end else if (m_halt_age == -1) begin
      if (r == 2) m_flush++;
      if (r != 2 && r != 5) m_stall++;
      if (r == 1) m_halt_age = 0;
    end else if (m_halt_age == 0) begin
      m_halt_age = 1;
    end
  endtask

  task automatic rnd_cycles(input int n, input bit allow_halt);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          allow_halt && ($urandom_range(0, 30) == 0));
    end
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; dmem_req = 1'b0;
    mispredict = 1'b0; load_use = 1'b0; halt_mem = 1'b0;

    // Reset with noisy inputs: outputs forced low.
    cyc(0, 1, 0, 1, 1, 1, 1);
    cyc(0, 1, 1, 0, 0, 0, 0);

    // Clean run.
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0, 0, 0);

    // Data miss for three cycles, then completion.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);

    // Redirect without fetch, redirect held across a freeze.
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 1, 0, 0);

    // Load-use bubble, also combined with fetch miss.
    cyc(1, 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);

    // Long fetch miss saturates the narrow stall counter.
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0, 0);

    rnd_cycles(150, 1'b0);

    // Halt blocked by a busy MEM, then halt with concurrent redirect.
    cyc(1, 1, 0, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 20; i++)
      cyc(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

    // Reset pulse out of the stopped state.
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 0, 0);

    // Reset while draining.
    cyc(1, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0, 0);

    // Random traffic with occasional halts and resets.
    for (int k = 0; k < 4; k++) begin
      rnd_cycles(60, 1'b1);
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
    rnd_cycles(30, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
